// File: rtl/mouse_packet_tracker.sv
// PS/2 mouse packet tracker: assembles 3-byte (or 4-byte IntelliMouse)
// packets from a byte stream, integrates the movement deltas into a clamped
// on-screen cursor position and latches button and wheel state.
module mouse_packet_tracker #(
    parameter int SCREEN_W    = 320,
    parameter int SCREEN_H    = 240,
    parameter int X_W         = 10,
    parameter int Y_W         = 9,
    parameter int SENS_SHIFT  = 0,
    parameter int WHEEL_EN    = 0,
    parameter int TIMEOUT_CYC = 50000
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [7:0]     received_data,
    input  logic           received_data_en,
    input  logic           recenter,
    output logic [X_W-1:0] x_position,
    output logic [Y_W-1:0] y_position,
    output logic           left_button,
    output logic           right_button,
    output logic           middle_button,
    output logic [3:0]     wheel_delta,
    output logic           packet_valid,
    output logic           sync_error
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_B2,
        ST_B3,
        ST_B4,
        ST_APPLY
    } state_t;

    localparam int             TO_W     = $clog2(TIMEOUT_CYC + 1);
    localparam logic [X_W-1:0] X_CENTER = X_W'(SCREEN_W / 2);
    localparam logic [Y_W-1:0] Y_CENTER = Y_W'(SCREEN_H / 2);
    localparam logic [X_W-1:0] X_MAX    = X_W'(SCREEN_W - 1);
    localparam logic [Y_W-1:0] Y_MAX    = Y_W'(SCREEN_H - 1);

    state_t            r_state;
    state_t            w_next_state;
    logic [TO_W-1:0]   r_timeout;

    // Skid register: holds a byte that arrives while APPLY is busy.
    logic [7:0]        r_skid;
    logic              r_skid_valid;

    // Byte 1 is kept as named fields; bit 3 is only the framing marker.
    logic [2:0]        r_btn;
    logic              r_x_sign;
    logic              r_y_sign;
    logic              r_x_ovf;
    logic              r_y_ovf;
    logic [7:0]        r_byte2;
    logic [7:0]        r_byte3;
    logic [3:0]        r_byte4;

    logic [X_W-1:0]    r_x;
    logic [Y_W-1:0]    r_y;
    logic [2:0]        r_btn_out;
    logic [3:0]        r_wheel;
    logic              r_packet_valid;
    logic              r_sync_error;

    logic              w_in_valid;
    logic [7:0]        w_in_data;
    logic              w_timeout_hit;
    logic              w_in_packet;
    logic              w_cap1;
    logic              w_cap2;
    logic              w_cap3;
    logic              w_cap4;
    logic              w_sync_err;

    logic signed [8:0]     w_dx;
    logic signed [8:0]     w_dy;
    logic signed [8:0]     w_dx_scaled;
    logic signed [8:0]     w_dy_scaled;
    logic signed [X_W+1:0] w_dx_ext;
    logic signed [Y_W+1:0] w_dy_ext;
    logic signed [X_W+1:0] w_new_x;
    logic signed [Y_W+1:0] w_new_y;
    logic [X_W-1:0]        w_clamp_x;
    logic [Y_W-1:0]        w_clamp_y;

    // A pending skid byte is consumed before any fresh strobe.
    assign w_in_valid    = (r_state != ST_APPLY) && (r_skid_valid || received_data_en);
    assign w_in_data     = r_skid_valid ? r_skid : received_data;
    assign w_in_packet   = (r_state == ST_B2) || (r_state == ST_B3) || (r_state == ST_B4);
    assign w_timeout_hit = (r_timeout == TO_W'(TIMEOUT_CYC - 1));

    // Next-state and byte-capture decode for the packet assembler.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        w_next_state = r_state;
        w_cap1       = 1'b0;
        w_cap2       = 1'b0;
        w_cap3       = 1'b0;
        w_cap4       = 1'b0;
        w_sync_err   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_in_valid) begin
                    if (w_in_data[3]) begin
                        w_cap1       = 1'b1;
                        w_next_state = ST_B2;
                    end else begin
                        w_sync_err = 1'b1;
                    end
                end
            end
            ST_B2: begin
                if (w_in_valid) begin
                    w_cap2       = 1'b1;
                    w_next_state = ST_B3;
                end else if (w_timeout_hit) begin
                    w_sync_err   = 1'b1;
                    w_next_state = ST_IDLE;
                end
            end
            ST_B3: begin
                if (w_in_valid) begin
                    w_cap3       = 1'b1;
                    w_next_state = (WHEEL_EN != 0) ? ST_B4 : ST_APPLY;
                end else if (w_timeout_hit) begin
                    w_sync_err   = 1'b1;
                    w_next_state = ST_IDLE;
                end
            end
            ST_B4: begin
                if (w_in_valid) begin
                    w_cap4       = 1'b1;
                    w_next_state = ST_APPLY;
                end else if (w_timeout_hit) begin
                    w_sync_err   = 1'b1;
                    w_next_state = ST_IDLE;
                end
            end
            ST_APPLY: w_next_state = ST_IDLE;
            default:  w_next_state = ST_IDLE;
        endcase
    end

    // Movement deltas, sensitivity scaling and clamped new cursor position.
    always_comb begin
        w_dx        = r_x_ovf ? 9'sd0 : $signed({r_x_sign, r_byte2});
        w_dy        = r_y_ovf ? 9'sd0 : $signed({r_y_sign, r_byte3});
        w_dx_scaled = w_dx >>> SENS_SHIFT;
        w_dy_scaled = w_dy >>> SENS_SHIFT;
        w_dx_ext    = {{(X_W - 7){w_dx_scaled[8]}}, w_dx_scaled};
        w_dy_ext    = {{(Y_W - 7){w_dy_scaled[8]}}, w_dy_scaled};
        // PS/2 reports +y as up while row 0 is the top of the screen.
        w_new_x     = $signed({2'b00, r_x}) + w_dx_ext;
        w_new_y     = $signed({2'b00, r_y}) - w_dy_ext;

        w_clamp_x = w_new_x[X_W-1:0];
        if (w_new_x[X_W+1]) begin
            w_clamp_x = '0;
        end else if (w_new_x > $signed({2'b00, X_MAX})) begin
            w_clamp_x = X_MAX;
        end

        w_clamp_y = w_new_y[Y_W-1:0];
        if (w_new_y[Y_W+1]) begin
            w_clamp_y = '0;
        end else if (w_new_y > $signed({2'b00, Y_MAX})) begin
            w_clamp_y = Y_MAX;
        end
    end

    // State register, inter-byte timeout counter and skid register.
    // NOTE: asynchronous active-low reset lives in the sensitivity list; it clears every register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= ST_IDLE;
            r_timeout    <= '0;
            r_skid       <= '0;
            r_skid_valid <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all registers update together.
            r_state <= w_next_state;

            if (w_in_packet && !w_in_valid && !w_timeout_hit) begin
                r_timeout <= r_timeout + TO_W'(1);
            end else begin
                r_timeout <= '0;
            end

            if (r_state == ST_APPLY) begin
                if (received_data_en) begin
                    r_skid       <= received_data;
                    r_skid_valid <= 1'b1;
                end
            end else if (r_skid_valid) begin
                if (received_data_en) begin
                    r_skid <= received_data;
                end else begin
                    r_skid_valid <= 1'b0;
                end
            end
        end
    end

    // Packet byte storage.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_btn    <= '0;
            r_x_sign <= 1'b0;
            r_y_sign <= 1'b0;
            r_x_ovf  <= 1'b0;
            r_y_ovf  <= 1'b0;
            r_byte2  <= '0;
            r_byte3  <= '0;
            r_byte4  <= '0;
        end else begin
            if (w_cap1) begin
                r_btn    <= w_in_data[2:0];
                r_x_sign <= w_in_data[4];
                r_y_sign <= w_in_data[5];
                r_x_ovf  <= w_in_data[6];
                r_y_ovf  <= w_in_data[7];
            end
            if (w_cap2) r_byte2 <= w_in_data;
            if (w_cap3) r_byte3 <= w_in_data;
            if (w_cap4) r_byte4 <= w_in_data[3:0];
        end
    end

    // Output registers: cursor, buttons, wheel and status pulses.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_x            <= X_CENTER;
            r_y            <= Y_CENTER;
            r_btn_out      <= '0;
            r_wheel        <= '0;
            r_packet_valid <= 1'b0;
            r_sync_error   <= 1'b0;
        end else begin
            r_packet_valid <= (r_state == ST_APPLY);
            r_sync_error   <= w_sync_err;

            // Recenter overrides a coincident packet's movement only.
            if (recenter) begin
                r_x <= X_CENTER;
                r_y <= Y_CENTER;
            end else if (r_state == ST_APPLY) begin
                r_x <= w_clamp_x;
                r_y <= w_clamp_y;
            end

            if (r_state == ST_APPLY) begin
                r_btn_out <= r_btn;
                r_wheel   <= (WHEEL_EN != 0) ? r_byte4 : 4'd0;
            end
        end
    end

    assign x_position    = r_x;
    assign y_position    = r_y;
    assign left_button   = r_btn_out[0];
    assign right_button  = r_btn_out[1];
    assign middle_button = r_btn_out[2];
    assign wheel_delta   = r_wheel;
    assign packet_valid  = r_packet_valid;
    assign sync_error    = r_sync_error;

endmodule
